sccb_master: RTL

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_master.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_master.sv
// sccb_master: single-byte SCCB (I2C-like) register access engine.
//
// A one-cycle Start latches the command. A write is
// START, 3 phases ({ID[7:1],0}, sub-address, data) and STOP. A read is
// START, 2 phases ({ID[7:1],0}, sub-address), STOP, GAP, START,
// 2 phases ({ID[7:1],1}, data byte from the slave) and STOP.
// Each phase is 8 bits MSB first plus a 9th bit.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   Start, Busy      request pulse / transaction in progress
//   DataOut          [31:24] device ID, [23:16] sub-address, [15:8] write data
//   DataIn           {24'h0, last read byte}
//   WR               [0]=1 write, [0]=0 read
//   ClockDiv         SIO_C half period T in clk cycles (0 treated as 1)
//   NegDel           SIO_C fall to SIO_D change delay (clamped to T-1)
//   SIO_C            SCCB clock, idle high
//   SIO_D_out/_oe    SCCB data drive value / drive enable
//   SIO_D_in         sampled SCCB data line
//   dbg_state        current FSM state
//
// Handshake: Start is a request that is taken only on a cycle where
// Busy=0 (FSM in IDLE); Busy rises on the following cycle and Start is
// ignored until Busy falls again.
module sccb_master (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Start,
    output logic        Busy,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    input  logic [3:0]  WR,
    input  logic [15:0] ClockDiv,
    input  logic [15:0] NegDel,
    output logic        SIO_C,
    output logic        SIO_D_out,
    output logic        SIO_D_oe,
    input  logic        SIO_D_in,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] SHIFT     = 3'd2;
    localparam logic [2:0] STOP_LOW  = 3'd3;
    localparam logic [2:0] STOP_HIGH = 3'd4;
    localparam logic [2:0] STOP_REL  = 3'd5;
    localparam logic [2:0] GAP       = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] t_q, t_d;
    logic [15:0] d_q, d_d;
    logic        half_q, half_d;    // 0: SIO_C low half, 1: high half
    logic [3:0]  bit_q, bit_d;      // 0..8 within a phase
    logic [1:0]  phase_q, phase_d;
    logic        seg_q, seg_d;      // 1: second (read) half of a read
    logic        wr_q, wr_d;
    logic [6:0]  id_q, id_d;
    logic [7:0]  sub_q, sub_d;
    logic [7:0]  wd_q, wd_d;
    logic [7:0]  rd_q, rd_d;
    logic [7:0]  din_q, din_d;

    logic [15:0] t_in, d_in;
    logic        t_last;
    logic [1:0]  last_phase;
    logic [1:0]  cur_drv, prev_drv, drv;
    logic        unused_ok;

    assign unused_ok = ^{WR[3:1], DataOut[24], DataOut[7:0]};

    // {out, oe} for bit bn of phase ph. The 9th bit of a master phase
    // releases the line; the 9th bit of the read byte drives NA=1.
    function automatic logic [1:0] bit_drive(input logic rseg,
                                             input logic [1:0] ph,
                                             input logic [3:0] bn);
        logic [7:0] b;
        logic       rd_data;
        logic [1:0] r;
        if (!rseg) begin
            case (ph)
                2'd0:    b = {id_q, 1'b0};
                2'd1:    b = sub_q;
                default: b = wd_q;
            endcase
        end else begin
            b = {id_q, 1'b1};
        end
        rd_data = rseg && (ph == 2'd1);
        if (bn == 4'd8)   r = rd_data ? 2'b11 : 2'b10;
        else if (rd_data) r = 2'b10;
        else              r = {b[3'd7 - bn[2:0]], 1'b1};
        return r;
    endfunction

    always_comb begin
        t_in = (ClockDiv == 16'd0) ? 16'd1 : ClockDiv;
        d_in = (NegDel < (t_in - 16'd1)) ? NegDel : (t_in - 16'd1);
        t_last = (cnt_q == (t_q - 16'd1));
        last_phase = (wr_q && !seg_q) ? 2'd2 : 2'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = t_last ? 16'd0 : cnt_q + 16'd1;
        t_d     = t_q;
        d_d     = d_q;
        half_d  = half_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        seg_d   = seg_q;
        wr_d    = wr_q;
        id_d    = id_q;
        sub_d   = sub_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (Start) begin
                    state_d = START;
                    t_d     = t_in;
                    d_d     = d_in;
                    wr_d    = WR[0];
                    id_d    = DataOut[31:25];
                    sub_d   = DataOut[23:16];
                    wd_d    = DataOut[15:8];
                    seg_d   = 1'b0;
                end
            end
            START: if (t_last) begin
                state_d = SHIFT;
                half_d  = 1'b0;
                bit_d   = 4'd0;
                phase_d = 2'd0;
            end
            SHIFT: begin
                // Slave data is taken on the last cycle of each high half.
                if (seg_q && phase_q == 2'd1 && half_q && t_last && bit_q < 4'd8)
                    rd_d = {rd_q[6:0], SIO_D_in};
                if (t_last) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (bit_q == 4'd8) begin
                            bit_d = 4'd0;
                            if (phase_q == last_phase) state_d = STOP_LOW;
                            else                       phase_d = phase_q + 2'd1;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            STOP_LOW:  if (t_last) state_d = STOP_HIGH;
            STOP_HIGH: if (t_last) state_d = STOP_REL;
            STOP_REL: if (t_last) begin
                if (!wr_q && !seg_q) begin
                    state_d = GAP;
                    seg_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (seg_q) din_d = rd_q;
                end
            end
            GAP: if (t_last) state_d = START;
            default: state_d = IDLE;
        endcase
    end

    // Within a bit's low half the line keeps the previous bit's value
    // until d_q cycles after SIO_C fell.
    always_comb begin
        cur_drv = bit_drive(seg_q, phase_q, bit_q);
        if (bit_q == 4'd0)
            prev_drv = (phase_q == 2'd0) ? 2'b01 : bit_drive(seg_q, phase_q - 2'd1, 4'd8);
        else
            prev_drv = bit_drive(seg_q, phase_q, bit_q - 4'd1);
        drv = (!half_q && cnt_q < d_q) ? prev_drv : cur_drv;

        SIO_C     = 1'b1;
        SIO_D_out = 1'b1;
        SIO_D_oe  = 1'b1;
        case (state_q)
            START:     SIO_D_out = 1'b0;
            SHIFT: begin
                SIO_C     = half_q;
                SIO_D_out = drv[1];
                SIO_D_oe  = drv[0];
            end
            STOP_LOW: begin
                SIO_C     = 1'b0;
                SIO_D_out = 1'b0;
            end
            STOP_HIGH: SIO_D_out = 1'b0;
            default: ;
        endcase
    end

    assign Busy      = (state_q != IDLE);
    assign DataIn    = {24'h0, din_q};
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            t_q     <= 16'd1;
            d_q     <= 16'd0;
            half_q  <= 1'b0;
            bit_q   <= 4'd0;
            phase_q <= 2'd0;
            seg_q   <= 1'b0;
            wr_q    <= 1'b0;
            id_q    <= 7'd0;
            sub_q   <= 8'd0;
            wd_q    <= 8'd0;
            rd_q    <= 8'd0;
            din_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            d_q     <= d_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            wr_q    <= wr_d;
            id_q    <= id_d;
            sub_q   <= sub_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            din_q   <= din_d;
        end
    end

endmodule
